// File: rtl/spmm_csr_window_sched_if.sv
// Start/row_end handshake and window output bundle between the LHS source,
// the CSR window scheduler and the PE array.
interface spmm_csr_window_sched_if #(
  parameter int N     = 16,
  parameter int LGN   = $clog2(N),
  parameter int PTR_W = 2*$clog2(N)+1
);
  logic               start_valid;
  logic               start_ready;
  logic [N*PTR_W-1:0] row_end;
  logic               err;
  logic               win_valid;
  logic               win_ready;
  logic [LGN-1:0]     win_idx;
  logic               win_last;
  logic [N-1:0]       lane_valid;
  logic [N-1:0]       split;
  logic               carry_in;
  logic [N-1:0]       row_done;
  logic [N-1:0]       row_empty;
  logic [N*LGN-1:0]   row_lane;

  modport master (
    output start_valid, row_end, win_ready,
    input  start_ready, err, win_valid, win_idx, win_last, lane_valid,
           split, carry_in, row_done, row_empty, row_lane
  );

  modport slave (
    input  start_valid, row_end, win_ready,
    output start_ready, err, win_valid, win_idx, win_last, lane_valid,
           split, carry_in, row_done, row_empty, row_lane
  );
endinterface

// File: rtl/spmm_csr_window_sched.sv
// Latches one CSR row_end vector per LHS tile and issues it to the PE array as
// N-lane windows carrying segmented-reduction and row-completion config.
//
// state | meaning
// IDLE  | waiting for a row_end vector (start_ready=1)
// CHECK | validating latched pointers (monotonic, total <= N*N)
// ISSUE | presenting windows; advances on each win_ready handshake
module spmm_csr_window_sched #(
  parameter int N = 16,
  localparam int LGN = $clog2(N),
  localparam int PTR_W = 2*LGN+1
) (
  input logic clock,
  input logic reset,
  spmm_csr_window_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_t;

  state_t             state_q, state_d;
  logic [N*PTR_W-1:0] row_end_q;
  logic               err_q, err_d;
  logic               load, clear;
  logic [LGN-1:0]     nxt_w;

  logic [LGN-1:0]     win_idx_q;
  logic               win_last_q, carry_in_q;
  logic [N-1:0]       lane_valid_q, split_q, row_done_q, row_empty_q;
  logic [N*LGN-1:0]   row_lane_q;

  logic [PTR_W-1:0]   re   [N];
  logic [PTR_W-1:0]   prev [N];
  logic [PTR_W-1:0]   nnz;
  logic               ptr_ok;

  logic [N-1:0]       lv_n, sp_n, rd_n, rem_n;
  logic [N*LGN-1:0]   rl_n;
  logic               last_n;

  always_comb begin
    for (int r = 0; r < N; r++) re[r] = row_end_q[r*PTR_W +: PTR_W];
    prev[0] = '0;
    for (int r = 1; r < N; r++) prev[r] = re[r-1];
    nnz = re[N-1];
  end

  always_comb begin
    ptr_ok = (nnz <= PTR_W'(N*N));
    for (int r = 1; r < N; r++)
      if (re[r] < prev[r]) ptr_ok = 1'b0;
  end

  // Fields for the window about to be loaded (index nxt_w).
  always_comb begin
    logic [PTR_W-1:0] g;
    logic [PTR_W-1:0] e;
    lv_n  = '0;
    sp_n  = '0;
    rd_n  = '0;
    rem_n = '0;
    rl_n  = '0;
    g     = '0;
    e     = '0;
    for (int k = 0; k < N; k++) begin
      g = (PTR_W'(nxt_w) << LGN) | PTR_W'(k);
      lv_n[k] = (g < nnz);
    end
    for (int r = 0; r < N; r++) begin
      e = re[r] - PTR_W'(1);
      if (re[r] == prev[r]) begin
        if (nxt_w == '0) begin
          rd_n[r]  = 1'b1;
          rem_n[r] = 1'b1;
        end
      end else if (e[PTR_W-1:LGN] == (PTR_W-LGN)'(nxt_w)) begin
        rd_n[r] = 1'b1;
        rl_n[r*LGN +: LGN] = e[LGN-1:0];
        sp_n[e[LGN-1:0]] = 1'b1;
      end
    end
    last_n = ((PTR_W'(nxt_w) + PTR_W'(1)) << LGN) >= nnz;
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    nxt_w   = win_idx_q + LGN'(1);
    case (state_q)
      IDLE:  if (bus.start_valid) state_d = CHECK;
      CHECK: begin
        nxt_w = '0;
        if (ptr_ok) begin
          load    = 1'b1;
          state_d = ISSUE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      ISSUE: if (bus.win_ready) begin
        if (win_last_q) begin
          clear   = 1'b1;
          state_d = IDLE;
        end else begin
          load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_end_q    <= '0;
      err_q        <= 1'b0;
      win_idx_q    <= '0;
      win_last_q   <= 1'b0;
      carry_in_q   <= 1'b0;
      lane_valid_q <= '0;
      split_q      <= '0;
      row_done_q   <= '0;
      row_empty_q  <= '0;
      row_lane_q   <= '0;
    end else begin
      err_q <= err_d;
      if (state_q == IDLE && bus.start_valid) row_end_q <= bus.row_end;
      if (load) begin
        win_idx_q    <= nxt_w;
        win_last_q   <= last_n;
        // Lane 0 continues a row unless the previous window closed on its last lane.
        carry_in_q   <= (nxt_w != '0) && !split_q[N-1];
        lane_valid_q <= lv_n;
        split_q      <= sp_n;
        row_done_q   <= rd_n;
        row_empty_q  <= rem_n;
        row_lane_q   <= rl_n;
      end else if (clear) begin
        win_idx_q    <= '0;
        win_last_q   <= 1'b0;
        carry_in_q   <= 1'b0;
        lane_valid_q <= '0;
        split_q      <= '0;
        row_done_q   <= '0;
        row_empty_q  <= '0;
        row_lane_q   <= '0;
      end
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.err         = err_q;
  assign bus.win_valid   = (state_q == ISSUE);
  assign bus.win_idx     = win_idx_q;
  assign bus.win_last    = win_last_q;
  assign bus.carry_in    = carry_in_q;
  assign bus.lane_valid  = lane_valid_q;
  assign bus.split       = split_q;
  assign bus.row_done    = row_done_q;
  assign bus.row_empty   = row_empty_q;
  assign bus.row_lane    = row_lane_q;
endmodule

// File: tb/tb_spmm_csr_window_sched.sv
// Directed bench for the CSR window scheduler at N=4 with hand-computed windows.
module tb_spmm_csr_window_sched;
  localparam int N = 4;
  localparam int LGN = 2;
  localparam int PTR_W = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  spmm_csr_window_sched_if #(.N(N), .LGN(LGN), .PTR_W(PTR_W)) bus ();

  spmm_csr_window_sched #(.N(N)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*PTR_W-1:0] pk(input int a, input int b, input int c, input int d);
    return {PTR_W'(d), PTR_W'(c), PTR_W'(b), PTR_W'(a)};
  endfunction

  function automatic logic [7:0] rl(input int a, input int b, input int c, input int d);
    return {2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a vector for one accept edge; returns at cycle t+2.
  task automatic start(input logic [N*PTR_W-1:0] v, input string tag);
    chk({tag, "_ready_t"}, 32'(bus.start_ready), 1);
    bus.start_valid = 1'b1;
    bus.row_end = v;
    tick();
    bus.start_valid = 1'b0;
    chk({tag, "_ready_t1"}, 32'(bus.start_ready), 0);
    tick();
  endtask

  task automatic win(input string tag, input int idx, input logic [3:0] lv, input logic [3:0] sp,
                     input logic ci, input logic [3:0] rd, input logic [3:0] rem,
                     input logic [7:0] lane, input logic last);
    chk({tag, "_valid"}, 32'(bus.win_valid), 1);
    chk({tag, "_idx"}, 32'(bus.win_idx), 32'(idx));
    chk({tag, "_lane_valid"}, 32'(bus.lane_valid), 32'(lv));
    chk({tag, "_split"}, 32'(bus.split), 32'(sp));
    chk({tag, "_carry_in"}, 32'(bus.carry_in), 32'(ci));
    chk({tag, "_row_done"}, 32'(bus.row_done), 32'(rd));
    chk({tag, "_row_empty"}, 32'(bus.row_empty), 32'(rem));
    chk({tag, "_row_lane"}, 32'(bus.row_lane), 32'(lane));
    chk({tag, "_last"}, 32'(bus.win_last), 32'(last));
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.start_ready), 1);
    chk({tag, "_win_valid"}, 32'(bus.win_valid), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_fields"}, 32'({bus.lane_valid, bus.split, bus.row_done, bus.row_empty,
                               bus.row_lane, bus.carry_in, bus.win_last, bus.win_idx}), 0);
  endtask

  task automatic handshake();
    bus.win_ready = 1'b1;
    tick();
    bus.win_ready = 1'b0;
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.row_end = '0;
    bus.win_ready = 1'b0;
    #1;
    idle_outputs("rst_hold");
    tick();
    tick();
    reset = 1'b0;
    tick();
    idle_outputs("rst_rel");

    // Case 1 with a 3-cycle stall on w0 and a stray start_valid while busy.
    start(pk(2, 3, 3, 7), "c1");
    win("c1_w0", 0, 4'b1111, 4'b0110, 0, 4'b0111, 4'b0100, rl(1, 2, 0, 0), 0);
    bus.start_valid = 1'b1;
    bus.row_end = pk(4, 8, 12, 16);
    for (int i = 0; i < 3; i++) begin
      tick();
      win("c1_w0_stall", 0, 4'b1111, 4'b0110, 0, 4'b0111, 4'b0100, rl(1, 2, 0, 0), 0);
      chk("c1_stall_ready", 32'(bus.start_ready), 0);
    end
    bus.start_valid = 1'b0;
    handshake();
    win("c1_w1", 1, 4'b0111, 4'b0100, 1, 4'b1000, 4'b0000, rl(0, 0, 0, 2), 1);
    handshake();
    idle_outputs("c1_done");

    // Case 2: no nonzeros still yields one window.
    start(pk(0, 0, 0, 0), "c2");
    win("c2_w0", 0, 4'b0000, 4'b0000, 0, 4'b1111, 4'b1111, rl(0, 0, 0, 0), 1);
    handshake();
    idle_outputs("c2_done");

    // Case 3: one full row per window, back-to-back handshakes.
    start(pk(4, 8, 12, 16), "c3");
    bus.win_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      win($sformatf("c3_w%0d", w), w, 4'b1111, 4'b1000, 0, 4'(1 << w), 4'b0000,
          8'(3 << (2*w)), (w == 3));
      tick();
    end
    bus.win_ready = 1'b0;
    idle_outputs("c3_done");

    // Case 4: non-monotonic and over-range pointers are rejected.
    start(pk(3, 2, 5, 6), "c4a");
    chk("c4a_err", 32'(bus.err), 1);
    chk("c4a_win_valid", 32'(bus.win_valid), 0);
    tick();
    idle_outputs("c4a_after");
    start(pk(4, 8, 12, 17), "c4b");
    chk("c4b_err", 32'(bus.err), 1);
    chk("c4b_win_valid", 32'(bus.win_valid), 0);
    tick();
    idle_outputs("c4b_after");

    // Case 6: reset while w1 pending discards the tile.
    start(pk(2, 3, 3, 7), "c6");
    handshake();
    win("c6_w1", 1, 4'b0111, 4'b0100, 1, 4'b1000, 4'b0000, rl(0, 0, 0, 2), 1);
    #2 reset = 1'b1;
    #1;
    idle_outputs("c6_rst");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_outputs("c6_quiet");
    end
    start(pk(4, 8, 12, 16), "c6_new");
    win("c6_new_w0", 0, 4'b1111, 4'b1000, 0, 4'b0001, 4'b0000, rl(3, 0, 0, 0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
